// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared definitions for the instruction fetch unit.
//   ADDR_W_DEF    default ROM word-address width
//   RESET_PC_DEF  default byte address of the first fetch after reset
//   fetch_entry_t one buffered fetch: {pc, data}
//   fetch_state_t RUN / FAULT (FAULT only reachable with RV_FETCH_MISALIGN_EN)
package rv_fetch_pkg;

  localparam int          ADDR_W_DEF   = 12;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: DEPTH-entry in-order prefetch buffer.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear; wins over push
//   push, push_entry  write one entry at the tail
//   pop          remove the head (ignored when empty)
//   count        number of valid entries
//   head, valid  head entry (zero when empty) and non-empty flag
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head,
  output logic          valid
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  // Masked so stale storage never shows on the outputs while empty.
  assign head = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch unit between the instruction ROM and decode.
// Issues one ROM read per cycle while the buffer has room (counting the read
// in flight), captures the registered ROM data a cycle later, and hands
// {pc, instruction} to decode over valid/ready. Redirects flush everything.
//   clk, rst_n          clock, asynchronous active-low reset
//   rom_addr            ROM word address (fetch_pc[ADDR_W+1:2])
//   rom_rdata           ROM data for the address presented last cycle
//   instr_valid/ready   decode handshake; instr_data, instr_pc at the head
//   redirect_valid/pc   single-cycle fetch restart request
//   fetch_fault         misaligned redirect target held
// Optional feature macro: RV_FETCH_MISALIGN_EN (misaligned redirects fault
// instead of being truncated to a word boundary).
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [31:0]       instr_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   target_pc;
  logic          fault_hold;
  logic          issue;
  logic          issue_ok;
  logic          pop;
  logic          push;
  logic [CW:0]   occ;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Issue-stage bookkeeping for the read now in flight.
  logic          vld_p1;
  logic          kill_p1;
  logic [31:0]   pc_p1;

`ifdef RV_FETCH_MISALIGN_EN
  fetch_state_t state;
  fetch_state_t state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_valid)
      state_nx = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
  end

  assign target_pc   = redirect_pc;
  assign fault_hold  = (state == ST_FAULT);
  assign fetch_fault = fault_hold;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign fault_hold  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // ---- stage p0: issue ----
  // The read in flight already owns a slot; a pop this cycle frees one.
  assign pop      = instr_valid && instr_ready;
  assign occ      = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign issue_ok = (occ < (CW+1)'(DEPTH));
  assign issue    = issue_ok && !fault_hold;
  assign rom_addr = fetch_pc[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
      kill_p1  <= 1'b0;
    end else begin
      vld_p1  <= issue;
      // A read issued in the redirect cycle belongs to the old stream.
      kill_p1 <= issue && redirect_valid;
      if (redirect_valid) fetch_pc <= target_pc;
      else if (issue)     fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc;
  end

  // ---- stage p1: ROM response capture ----
  assign push       = vld_p1 && !kill_p1 && !redirect_valid;
  assign push_entry = '{pc: pc_p1, data: rom_rdata};

  rv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .valid      (instr_valid)
  );

  // ---- stage p2: decode handoff ----
  assign instr_data = head.data;
  assign instr_pc   = head.pc;

endmodule

// File: tb/tb_rv_fetch.sv
// tb_rv_fetch: scoreboard bench for rv_fetch. Expected {pc, data} pairs are
// queued when a stream is started and checked at every accepted handshake.
module tb_rv_fetch;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_data;
  logic [31:0]       instr_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fetch_fault;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q [$];
  logic [63:0] sb_e;

  rv_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // ROM: word i holds i*0x11, registered read.
  always @(posedge clk) rom_rdata <= 32'(rom_addr) * 32'h11;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [ADDR_W-1:0] w;
    w = pc[ADDR_W+1:2];
    return 32'(w) * 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({pc0 + 32'(4 * i), rom_word(pc0 + 32'(4 * i))});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cyc();
      smp();
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("sb_pc", instr_pc, sb_e[63:32]);
        chk("sb_data", instr_data, sb_e[31:0]);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    run(3);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'h0);

    // Stream from reset with decode always ready, then redirect on a pop.
    exp_push(32'h0, 8);
    cyc(); rst_n = 1'b1;                        // c0
    smp(); chk("c0_valid", 32'(instr_valid), 32'd0);
    run(1); chk("c1_valid", 32'(instr_valid), 32'd0);
    run(1); chk("c2_valid", 32'(instr_valid), 32'd1);
    chk("c2_pc", instr_pc, 32'h0);
    for (int i = 3; i <= 8; i++) begin
      run(1);
      chk("run_nogap", 32'(instr_valid), 32'd1);
    end
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100;   // N: pops 0x1C
    exp_push(32'h100, 4);
    smp(); chk("redir_pop_pc", instr_pc, 32'h1C);
    cyc(); redirect_valid = 1'b0;
    smp(); chk("redir_n1_valid", 32'(instr_valid), 32'd0);
    run(1); chk("redir_n2_valid", 32'(instr_valid), 32'd0);
    run(1); chk("redir_n3_valid", 32'(instr_valid), 32'd1);
    chk("redir_n3_pc", instr_pc, 32'h100);
    run(3);
    cyc(); instr_ready = 1'b0; smp();

    // Reset mid-operation, then stall decode for 5 cycles after first valid.
    cyc(); rst_n = 1'b0; #1;
    chk("rst_mid_valid", 32'(instr_valid), 32'd0);
    chk("rst_mid_addr", 32'(rom_addr), 32'h0);
    chk("sb_drained_a", 32'(exp_q.size()), 32'd0);
    run(2);
    exp_push(32'h0, 6);
    cyc(); rst_n = 1'b1;                        // c0
    smp(); run(1);
    for (int i = 2; i <= 6; i++) begin
      run(1);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", instr_pc, 32'h0);
      chk("stall_addr", 32'(rom_addr), 32'(DEPTH));
    end
    cyc(); instr_ready = 1'b1;                  // c7
    smp(); chk("release_valid", 32'(instr_valid), 32'd1);
    for (int i = 8; i <= 12; i++) begin
      run(1);
      chk("release_nogap", 32'(instr_valid), 32'd1);
    end
    cyc(); instr_ready = 1'b0; smp();

    // Address wrap at the top of the ROM.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h3FF8;
    exp_push(32'h3FF8, 4);
    smp();
    cyc(); redirect_valid = 1'b0; instr_ready = 1'b1;
    smp(); chk("wrap_n1_valid", 32'(instr_valid), 32'd0);
    chk("wrap_n1_addr", 32'(rom_addr), 32'((1 << ADDR_W) - 2));
    run(1); chk("wrap_n2_valid", 32'(instr_valid), 32'd0);
    run(1); chk("rom_addr_wrap", 32'(rom_addr), 32'h0);
    chk("wrap_n3_pc", instr_pc, 32'h3FF8);
    run(1);
    run(1); chk("pc_wrap", instr_pc, 32'h4000);
    run(1);
    cyc(); instr_ready = 1'b0; smp();

    // Misaligned redirect target.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h102;
`ifdef RV_FETCH_MISALIGN_EN
    smp();
    cyc(); redirect_valid = 1'b0; instr_ready = 1'b1;
    smp();
    for (int i = 1; i <= 4; i++) begin
      chk("fault_set", 32'(fetch_fault), 32'd1);
      chk("fault_valid", 32'(instr_valid), 32'd0);
      run(1);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;   // already #1 after an edge? re-align below
    redirect_valid = 1'b0;
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;   // M
    exp_push(32'h200, 4);
    smp(); chk("fault_m_set", 32'(fetch_fault), 32'd1);
    cyc(); redirect_valid = 1'b0;
    smp(); chk("fault_clear", 32'(fetch_fault), 32'd0);
    chk("fault_m1_valid", 32'(instr_valid), 32'd0);
    run(1); chk("fault_m2_valid", 32'(instr_valid), 32'd0);
    run(1); chk("fault_m3_valid", 32'(instr_valid), 32'd1);
    chk("fault_m3_pc", instr_pc, 32'h200);
    run(3);
    cyc(); instr_ready = 1'b0; smp();
`else
    exp_push(32'h100, 4);
    smp();
    cyc(); redirect_valid = 1'b0; instr_ready = 1'b1;
    smp(); chk("trunc_fault", 32'(fetch_fault), 32'd0);
    chk("trunc_n1_valid", 32'(instr_valid), 32'd0);
    run(1);
    run(1); chk("trunc_n3_valid", 32'(instr_valid), 32'd1);
    chk("trunc_n3_pc", instr_pc, 32'h100);
    chk("trunc_fault_n3", 32'(fetch_fault), 32'd0);
    run(3);
    cyc(); instr_ready = 1'b0; smp();
`endif

    run(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
